// File: rtl/fmap_pad_streamer_pkg.sv
// rtl/fmap_pad_streamer_pkg.sv - padded geometry and FSM encoding shared by streamer and window buffer
package fmap_pad_streamer_pkg;

  localparam int H_DEF   = 32;
  localparam int W_DEF   = 128;
  localparam int D_DEF   = 512;
  localparam int PAD_DEF = 1;

  function automatic int padded(input int n, input int pad);
    return n + 2 * pad;
  endfunction

  // Counters are sized for 0..n-1; a 1-deep dimension still needs one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PH    = padded(H_DEF, PAD_DEF);
  localparam int PW    = padded(W_DEF, PAD_DEF);
  localparam int BEATS = PH * PW;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_LAST   = 2'd2
  } state_e;

endpackage

// File: rtl/fmap_pad_streamer_pos.sv
// rtl/fmap_pad_streamer_pos.sv - pad_pos_counter: padded row/col raster position with last/data flags
module pad_pos_counter
  import fmap_pad_streamer_pkg::*;
#(
  parameter int H   = 2,
  parameter int W   = 3,
  parameter int PAD = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_adv,
  output logic o_last,
  output logic o_is_data
);

  localparam int P_H  = padded(H, PAD);
  localparam int P_W  = padded(W, PAD);
  localparam int RW   = cnt_width(P_H);
  localparam int CW   = cnt_width(P_W);
  localparam int PHM1 = P_H - 1;
  localparam int PWM1 = P_W - 1;

  localparam logic [RW-1:0] ROW_MAX = PHM1[RW-1:0];
  localparam logic [CW-1:0] COL_MAX = PWM1[CW-1:0];
  localparam logic [RW:0]   ROW_LO  = PAD[RW:0];
  localparam logic [CW:0]   COL_LO  = PAD[CW:0];
  localparam logic [RW:0]   ROW_N   = H[RW:0];
  localparam logic [CW:0]   COL_N   = W[CW:0];

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic [RW:0]   w_row_off;
  logic [CW:0]   w_col_off;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_adv) begin
      if (r_col == COL_MAX) begin
        r_col <= '0;
        r_row <= (r_row == ROW_MAX) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // One extra bit lets positions before the border wrap far above H/W,
  // so a single unsigned compare covers both edges of the data window.
  assign w_row_off = {1'b0, r_row} - ROW_LO;
  assign w_col_off = {1'b0, r_col} - COL_LO;
  assign o_is_data = (w_row_off < ROW_N) && (w_col_off < COL_N);
  assign o_last    = (r_row == ROW_MAX) && (r_col == COL_MAX);

endmodule

// File: rtl/fmap_pad_streamer.sv
// rtl/fmap_pad_streamer.sv - zero-pads an unpadded raster feature map into the shift-register beat stream
module fmap_pad_streamer
  import fmap_pad_streamer_pkg::*;
#(
  parameter int H   = H_DEF,
  parameter int W   = W_DEF,
  parameter int D   = D_DEF,
  parameter int PAD = PAD_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [D-1:0] data_in,
  output logic         out_en,
  input  logic         out_ready,
  output logic [D-1:0] data_out,
  output logic         busy,
  output logic         frame_done
);

  state_e       r_state;
  state_e       w_state_nxt;
  logic         w_last;
  logic         w_is_data;
  logic         w_free;
  logic         w_load;
  logic         w_clr;
  logic         w_done_xfer;
  logic         r_out_en;
  logic [D-1:0] r_data;
  logic         r_frame_done;

  pad_pos_counter #(.H(H), .W(W), .PAD(PAD)) u_pos (
    .i_clk     (clk),
    .i_rst_n   (rst),
    .i_clr     (w_clr),
    .i_adv     (w_load),
    .o_last    (w_last),
    .o_is_data (w_is_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start && !r_frame_done) w_state_nxt = ST_STREAM;
      ST_STREAM: if (w_load && w_last)       w_state_nxt = ST_LAST;
      ST_LAST:   if (out_ready)              w_state_nxt = ST_IDLE;
      default:                               w_state_nxt = ST_IDLE;
    endcase
  end

  // A start landing on the frame_done cycle is dropped so back-to-back frames need a gap cycle.
  always_comb begin
    w_free      = !r_out_en || out_ready;
    w_clr       = (r_state == ST_IDLE) && start && !r_frame_done;
    w_load      = (r_state == ST_STREAM) && w_free && (!w_is_data || in_valid);
    w_done_xfer = (r_state == ST_LAST) && out_ready;
    in_ready    = (r_state == ST_STREAM) && w_free && w_is_data;
    busy        = (r_state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_en     <= 1'b0;
      r_data       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_done_xfer;
      if (w_load) begin
        r_out_en <= 1'b1;
        r_data   <= w_is_data ? data_in : '0;
      end else if (w_free) begin
        r_out_en <= 1'b0;
        r_data   <= '0;
      end
    end
  end

  assign out_en     = r_out_en;
  assign data_out   = r_data;
  assign frame_done = r_frame_done;

endmodule

// File: doc/fmap_pad_streamer.md
# fmap_pad_streamer

Transmit-side companion to the input feature-map shift register. It accepts an unpadded H×W feature map as a raster stream of D-bit pixels over a valid/ready handshake. It emits the zero-padded (H+2·PAD)×(W+2·PAD) raster stream, one pixel per `out_en` beat, which drives the shift register's `in_en`/`data_in` directly. It sits between the previous layer's output collector (or input DMA) and each convolution stage's window buffer.

## Interface
- `H`, 32, unpadded map height (rows)
- `W`, 128, unpadded map width (columns)
- `D`, 512, pixel width in bits (map depth, 1 bit per channel)
- `PAD`, 1, zero border on every side; 0 is legal (pass-through)
- `clk`  input  1  sole clock, rising edge
- `rst`  input  1  reset; one clock, reset is asynchronous and active-low
- `start`  input  1  one-cycle pulse; begins a frame when idle, ignored otherwise
- `in_valid`  input  1  `data_in` holds the next unpadded pixel
- `in_ready`  output  1  block consumes `data_in` this cycle when `in_valid` is high
- `data_in`  input  D  unpadded pixel, raster order (row-major, column 0 first)
- `out_en`  output  1  `data_out` valid; connects to shift register `in_en`
- `out_ready`  input  1  downstream accepts; tie high when feeding the shift register directly
- `data_out`  output  D  padded pixel; all-zero on border positions
- `busy`  output  1  high from accepted `start` until the frame's last beat transfers
- `frame_done`  output  1  one-cycle pulse on the cycle after the last beat transfers

## Operation
- Counters: `row` 0..H+2·PAD−1 and `col` 0..W+2·PAD−1 track the next padded position to emit. Each is sized $clog2(max+1). `col` wraps to 0 and increments `row` at W+2·PAD−1.
- A position is a data position when PAD ≤ row < PAD+H and PAD ≤ col < PAD+W. Otherwise it is a pad position.
- FSM states:
  - IDLE: `start` → STREAM, counters cleared, `busy`=1.
  - STREAM: emits positions in raster order.
  - LAST: final beat is held in the output register awaiting `out_ready`; the beat transfers → IDLE, with `frame_done` pulsed.
- Output stage: a single register holding `out_en`/`data_out`. The register is free when `out_en`=0 or `out_ready`=1. A new beat is loaded only when the register is free.
- Pad position with the register free: load zeros, advance counters. No input is consumed.
- Data position with the register free: `in_ready`=1. When `in_valid` is also high, load `data_in` and advance counters. When `in_valid` is low, hold the position; `out_en` drops after the current beat drains (a bubble).
- `in_ready` is 0 in IDLE, in LAST, and on every pad position.
- Loading position (H+2·PAD−1, W+2·PAD−1) enters LAST.
- Exactly (H+2·PAD)·(W+2·PAD) beats per frame. Exactly H·W input transfers per frame.
- PAD=0: every position is a data position, so output equals input delayed one cycle.

## Timing
- Reset values: `in_ready`=0, `out_en`=0, `data_out`=0, `busy`=0, `frame_done`=0; FSM=IDLE; counters 0.
- Reset asserted mid-frame aborts immediately: no `frame_done`, and any remaining input pixels are not consumed.
- Latency: `start` at cycle 0 → first beat (`out_en`=1) at cycle 2.
- Input transfer at edge n → matching `data_out` visible after edge n, i.e. one-cycle latency.
- With `out_ready`=1 and `in_valid`=1 continuously, the block sustains one beat per cycle with no bubbles, including across row wraps and the pad/data boundaries.
- `out_ready` low holds `out_en`/`data_out` stable. Counters do not advance and `in_ready` is 0.
- `start` in the same cycle as `frame_done`, or while `busy`, is ignored. A new frame may start the cycle after `frame_done`.
- `data_out` is zero whenever `out_en` is 0.

## Structure
- The shared package holds the padded geometry localparams `PH`=H+2·PAD, `PW`=W+2·PAD, `BEATS`=PH·PW, and the FSM state encoding (IDLE, STREAM, LAST). The window-buffer side reuses the same `PW`.
- One sub-module: `pad_pos_counter`, containing the `row`/`col` counters with wrap, a `last` flag and an `is_data` flag. The output register and the FSM stay in the top level.

## Test plan
- H=2, W=3, D=8, PAD=1, `out_ready`=1, `in_valid`=1, inputs 1..6:
  - Expect 20 beats: 0×6, 1,2,3, 0,0, 4,5,6, 0×6.
  - `in_ready` high on exactly 6 cycles.
  - `frame_done` on cycle 22 after `start`.
- Same configuration with `in_valid` toggling every other cycle: identical output sequence with bubbles only at data positions; beat count still 20.
- `out_ready` held low for 3 cycles mid-row: `data_out` holds its value, and no input is consumed while stalled.
- PAD=0, H=2, W=2: 4 beats equal to inputs, each delayed 1 cycle.
- `rst` pulled low at beat 10, then a new `start`: all outputs are 0 during reset, and the new frame restarts at position (0,0) with 20 beats.
- `start` pulsed while `busy`: ignored; the frame completes normally with a single `frame_done`.
